pnn_neuron_param: RTL
=====================

Name: pnn_neuron_param

Overview:
Parametrised pattern neuron for the FAPNN datapath. It holds a DEPTH-entry weight vector and runs in one of two modes per operation. Train mode stores an input pattern as the weight vector. Infer mode computes the dot product of an input vector with the stored weights and compares it against a threshold sigma. It replaces the fixed 4-entry, DSP-IP-based neuron with a self-contained, handshaked, width/depth-generic block; many instances sit in parallel in the pattern layer.

Parameters:
DATA_W, 16, width of input samples, weights and sigma (unsigned)
DEPTH, 4, number of elements per vector (>=2)
ACC_W, 48, accumulator width; must be >= 2*DATA_W + clog2(DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin an operation; sampled only in IDLE
train  in  1  mode select, sampled with start: 1 = store pattern, 0 = infer
sigma  in  DATA_W  threshold, sampled with start (infer only)
in_valid  in  1  input sample valid
in_data  in  DATA_W  input sample
in_ready  out  1  block accepts a sample this cycle
busy  out  1  operation in progress
acc  out  ACC_W  accumulator value; holds the final dot product after DONE
y  out  1  classification result, held until next infer completes
y_valid  out  1  one-cycle pulse when y/acc are updated by infer
train_done  out  1  one-cycle pulse when a pattern store completes

Behaviour:
- Reset (async assert, sync release): state IDLE, idx=0, acc=0, y=0, y_valid=0, train_done=0, busy=0, in_ready=0, latched sigma=0, latched mode=infer. Weight storage is NOT reset; its content is undefined after power-up and is retained across rst_n.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, busy=0. On start=1, latch train and sigma, set idx=0, and go to RUN. In infer mode, also clear acc to 0 on the same edge. acc and y hold their previous values otherwise.
- RUN: busy=1, in_ready=1. A sample is accepted on each edge where in_valid=1. Bubbles (in_valid=0) stall with no state change.
  - Train accept: weight[idx] <= in_data.
  - Infer accept: acc <= acc + in_data*weight[idx]. Unsigned product is 2*DATA_W wide, zero-extended to ACC_W, and no overflow is possible given the ACC_W rule.
  - After the accept with idx==DEPTH-1: idx wraps to 0 and state goes to DONE. Otherwise idx increments.
- DONE (exactly one cycle): busy=1, in_ready=0.
  - Infer: y <= (acc > {zero-extended sigma}) (strict greater-than) and y_valid=1.
  - Train: train_done=1, and acc/y are unchanged.
  - Next state is IDLE.
- Latency: an infer with no bubbles takes start edge + DEPTH accept cycles + 1 DONE cycle. y_valid is asserted DEPTH+1 cycles after the start edge.
- start is ignored while busy (RUN/DONE), and there is no re-trigger. A start in the cycle after DONE (IDLE) is accepted normally. Back-to-back operations therefore have a minimum 1-cycle IDLE gap.
- Changing train or sigma during RUN has no effect; the latched copies are used.
- Reading and writing the same weight index in one operation cannot happen, because modes are exclusive per operation.
- rst_n asserted mid-RUN aborts the operation: no y_valid or train_done pulse, acc cleared. Weights already written by a partial train are kept and the unwritten entries retain their old values.
- in_valid in IDLE or DONE is ignored and no sample is consumed.

Test Plan:
- Train then infer: DEPTH=4, train with [1,2,3,4], then infer [1,1,1,1] with sigma=9 -> acc=10, y=1. train_done pulses once, and y_valid pulses exactly 5 cycles after the infer start edge.
- Threshold equality: same weights, infer [1,1,1,1] with sigma=10 -> acc=10, y=0 (strict >). Repeat with sigma=11 -> y=0.
- Max values: weights all 0xFFFF, inputs all 0xFFFF -> acc=4*0xFFFE0001=0x3FFF80004 with no wrap, y=1 for sigma=0xFFFF.
- Bubbles and busy start: infer with in_valid low on alternate cycles and start held high throughout -> same acc as without bubbles, one y_valid only, and a second op starts in the first IDLE cycle.
- Reset mid-operation: assert rst_n low after 2 samples of a train with [9,9,9,9] over stored [1,2,3,4] -> outputs return to reset values, no train_done. A subsequent infer of [1,1,1,1] gives acc=9+9+3+4=25.
- Parameter sweep: DATA_W=8, DEPTH=7, ACC_W=19 with random vectors vs. a reference model -> acc and y match over 1000 operations.

Source files
------------

// File: rtl/pnn_neuron_param.sv
// Pattern-layer neuron: train stores an input vector as weights, infer
// accumulates the dot product with the stored weights and thresholds it on sigma.
module pnn_neuron_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              train,
    input  logic [DATA_W-1:0] sigma,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic [ACC_W-1:0]  acc,
    output logic              y,
    output logic              y_valid,
    output logic              train_done
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              idx;
    logic                          mode_train;
    logic [DATA_W-1:0]             sigma_q;
    logic [DEPTH-1:0][DATA_W-1:0]  weight;
    logic [2*DATA_W-1:0]           prod;
    logic                          accept;
    logic                          last;

    assign accept = (state == RUN) && in_valid;
    assign last   = (idx == IDX_W'(DEPTH - 1));
    assign prod   = in_data * weight[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (in_valid && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            RUN:     begin in_ready = 1'b1; busy = 1'b1; end
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            mode_train <= 1'b0;
            sigma_q    <= '0;
            acc        <= '0;
            y          <= 1'b0;
            y_valid    <= 1'b0;
            train_done <= 1'b0;
        end else begin
            y_valid    <= 1'b0;
            train_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode_train <= train;
                    sigma_q    <= sigma;
                    idx        <= '0;
                    if (!train) acc <= '0;
                end
                RUN: if (in_valid) begin
                    if (!mode_train)
                        acc <= acc + {{(ACC_W-2*DATA_W){1'b0}}, prod};
                    idx <= last ? '0 : idx + 1'b1;
                end
                DONE: begin
                    if (mode_train) begin
                        train_done <= 1'b1;
                    end else begin
                        y       <= (acc > {{(ACC_W-DATA_W){1'b0}}, sigma_q});
                        y_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weights deliberately have no reset: they survive rst_n, including partial trains.
    always_ff @(posedge clk) begin
        if (accept && mode_train) weight[idx] <= in_data;
    end
endmodule
